// File: rtl/dr_ald_pkg.sv
// rtl/dr_ald_pkg.sv - shared widths, stage payload types and helpers for the approximate log divider
//   No ports; imported by dr_ald_pipe and dr_ald_antilog.
package dr_ald_pkg;

  localparam int A_W   = 16;  // dividend width
  localparam int B_W   = 8;   // divisor width
  localparam int Q_W   = 16;  // quotient width
  localparam int K1_W  = 4;   // leading-one position of the dividend, 0..15
  localparam int K2_W  = 3;   // leading-one position of the divisor, 0..7
  localparam int E_W   = 5;   // signed exponent difference, -8..15
  localparam int T_MAX = 7;   // widest legal truncated fraction

  // Stage 1 payload: log-domain operands. Fraction fields are sized for the
  // widest legal truncation; for narrower builds the upper bits stay zero.
  typedef struct packed {
    logic [K1_W-1:0]  k1;
    logic [K2_W-1:0]  k2;
    logic [T_MAX-1:0] x1t;
    logic [T_MAX-1:0] x2t;
    logic             zero_a;
    logic             dbz;
  } s1_t;

  // Stage 2 payload: log-domain quotient split into exponent and mantissa.
  typedef struct packed {
    logic [E_W-1:0] e;
    logic [T_MAX:0] m;
    logic           zero_a;
    logic           dbz;
  } s2_t;

  // Highest set bit position; returns 0 for a zero input (callers flag zero separately).
  function automatic logic [K1_W-1:0] find_leading_one16(input logic [A_W-1:0] v);
    logic [K1_W-1:0] pos;
    pos = '0;
    for (int i = 0; i < A_W; i++) begin
      if (v[i]) pos = K1_W'(i);
    end
    return pos;
  endfunction

  function automatic logic [K2_W-1:0] find_leading_one8(input logic [B_W-1:0] v);
    logic [K2_W-1:0] pos;
    pos = '0;
    for (int i = 0; i < B_W; i++) begin
      if (v[i]) pos = K2_W'(i);
    end
    return pos;
  endfunction

endpackage

// File: rtl/dr_ald_antilog.sv
// rtl/dr_ald_antilog.sv - combinational antilog shift plus divide-by-zero / zero-dividend override
//   e      in  [E_W-1:0]  signed exponent of the quotient
//   m      in  [T_MAX:0]  mantissa {1, fraction}, TRUNC_WIDTH fraction bits in the LSBs
//   zero_a in  1          dividend was zero
//   dbz    in  1          divisor was zero
//   q      out [Q_W-1:0]  integer quotient (floor)
//   q_dbz  out 1          divide-by-zero flag
module dr_ald_antilog
  import dr_ald_pkg::*;
#(
  parameter int TRUNC_WIDTH = 6
) (
  input  logic [E_W-1:0] e,
  input  logic [T_MAX:0] m,
  input  logic           zero_a,
  input  logic           dbz,
  output logic [Q_W-1:0] q,
  output logic           q_dbz
);

  logic [31:0] shifted;

  // With e <= 15 and m < 2^(t+1) the shifted value is below 2^(16+t),
  // so dropping the t fraction bits always leaves a 16-bit result.
  always_comb begin
    shifted = 32'(m) << e[E_W-2:0];
    q       = Q_W'(shifted >> TRUNC_WIDTH);
    q_dbz   = 1'b0;
    if (dbz) begin
      q     = '1;
      q_dbz = 1'b1;
    end else if (zero_a || e[E_W-1]) begin
      // A negative exponent means the true quotient is below 1.
      q = '0;
    end
  end

endmodule

// File: rtl/dr_ald_pipe.sv
// rtl/dr_ald_pipe.sv - 3-stage elastic Mitchell-style approximate divider, 16-bit / 8-bit
//   i_clk   in  1   clock
//   i_rst_n in  1   asynchronous active-low reset
//   i_valid in  1   input beat valid
//   o_ready out 1   block can accept input this cycle
//   i_a     in  16  dividend, unsigned
//   i_b     in  8   divisor, unsigned
//   o_valid out 1   result valid
//   i_ready in  1   downstream accepts result
//   o_q     out 16  approximate quotient (floor)
//   o_dbz   out 1   divide-by-zero flag, qualified by o_valid
module dr_ald_pipe
  import dr_ald_pkg::*;
#(
  parameter int TRUNC_WIDTH = 6
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           i_valid,
  output logic           o_ready,
  input  logic [A_W-1:0] i_a,
  input  logic [B_W-1:0] i_b,
  output logic           o_valid,
  input  logic           i_ready,
  output logic [Q_W-1:0] o_q,
  output logic           o_dbz
);

  localparam int T = TRUNC_WIDTH;

  logic s1_valid, s2_valid, s3_valid;
  logic s1_adv, s2_adv, s3_adv;

  s1_t s1_c, s1_q;
  s2_t s2_c, s2_q;

  logic [K1_W-1:0] k1_c;
  logic [K2_W-1:0] k2_c;
  logic [T-2:0]    x1_top;
  logic [T-2:0]    x2_top;

  logic [T_MAX:0]  d_full;
  logic            d_neg;
  logic [T-1:0]    d_low;

  logic [Q_W-1:0]  q_c, q_q;
  logic            dbz_c, dbz_q;

  // Each stage moves when it is empty or its successor moves; the ready chain
  // runs back combinationally from i_ready so a full pipe still streams.
  assign s3_adv  = !s3_valid || i_ready;
  assign s2_adv  = !s2_valid || s3_adv;
  assign s1_adv  = !s1_valid || s2_adv;
  assign o_ready = s1_adv;

  assign o_valid = s3_valid;
  assign o_q     = q_q;
  assign o_dbz   = dbz_q;

  // Stage 1: log conversion. Shifting the operand so its leading one sits at
  // the MSB, then dropping the MSB, gives the left-aligned fraction; only the
  // top t-1 bits are kept and a 1 is forced in as the LSB.
  always_comb begin
    k1_c   = find_leading_one16(i_a);
    k2_c   = find_leading_one8(i_b);
    x1_top = (T-1)'((i_a << (4'd15 - k1_c)) >> (A_W - T));
    x2_top = (T-1)'((i_b << (3'd7 - k2_c)) >> (B_W - T));

    s1_c        = '0;
    s1_c.k1     = k1_c;
    s1_c.k2     = k2_c;
    s1_c.x1t    = T_MAX'({x1_top, 1'b1});
    s1_c.x2t    = T_MAX'({x2_top, 1'b1});
    s1_c.zero_a = (i_a == '0);
    s1_c.dbz    = (i_b == '0);
  end

  // Stage 2: log subtract. Both fractions are below 2^t, so the top bit of the
  // wide difference is the borrow; a borrow moves one unit out of the exponent
  // and the low t bits are the (wrapped) fraction of the quotient.
  always_comb begin
    d_full = {1'b0, s1_q.x1t} - {1'b0, s1_q.x2t};
    d_neg  = d_full[T_MAX];
    d_low  = T'(d_full);

    s2_c        = '0;
    s2_c.e      = {1'b0, s1_q.k1} - {2'b0, s1_q.k2} - {{(E_W-1){1'b0}}, d_neg};
    s2_c.m      = (T_MAX+1)'({1'b1, d_low});
    s2_c.zero_a = s1_q.zero_a;
    s2_c.dbz    = s1_q.dbz;
  end

  // Stage 3: antilog and special-case override.
  dr_ald_antilog #(
    .TRUNC_WIDTH (T)
  ) u_antilog (
    .e      (s2_q.e),
    .m      (s2_q.m),
    .zero_a (s2_q.zero_a),
    .dbz    (s2_q.dbz),
    .q      (q_c),
    .q_dbz  (dbz_c)
  );

  // Payload registers load only with a valid beat so a drained stage keeps its
  // last contents rather than picking up upstream noise.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else if (s1_adv) begin
      s1_valid <= i_valid;
      if (i_valid) s1_q <= s1_c;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s2_valid <= 1'b0;
      s2_q     <= '0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) s2_q <= s2_c;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s3_valid <= 1'b0;
      q_q      <= '0;
      dbz_q    <= 1'b0;
    end else if (s3_adv) begin
      s3_valid <= s2_valid;
      if (s2_valid) begin
        q_q   <= q_c;
        dbz_q <= dbz_c;
      end
    end
  end

endmodule

// File: tb/tb_dr_ald_pipe.sv
// tb/tb_dr_ald_pipe.sv - self-checking bench for dr_ald_pipe with a log-domain reference model
module tb_dr_ald_pipe;

  localparam int T = 6;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [7:0]  b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] q;
  logic        dbz;

  int          total = 0;
  int          bad   = 0;
  int          n_out = 0;
  logic [16:0] exp_q[$];

  dr_ald_pipe #(.TRUNC_WIDTH(T)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_valid (in_valid),
    .o_ready (in_ready),
    .i_a     (a),
    .i_b     (b),
    .o_valid (out_valid),
    .i_ready (out_ready),
    .o_q     (q),
    .o_dbz   (dbz)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Mitchell division in plain integer arithmetic: log value = k*2^t + truncated
  // fraction (in units of 2^-t, LSB forced to 1); quotient = antilog of the difference.
  function automatic logic [16:0] model(input logic [15:0] av, input logic [7:0] bv);
    int k1, k2, x1t, x2t, lq, e, fr, qq;
    if (bv == 0) return {1'b1, 16'hFFFF};
    if (av == 0) return 17'd0;
    k1  = $clog2(int'(av) + 1) - 1;
    k2  = $clog2(int'(bv) + 1) - 1;
    x1t = ((int'(av) - (1 << k1)) * (1 << (T-1)) / (1 << k1)) * 2 + 1;
    x2t = ((int'(bv) - (1 << k2)) * (1 << (T-1)) / (1 << k2)) * 2 + 1;
    lq  = (k1 - k2) * (1 << T) + x1t - x2t;
    if (lq < 0) return 17'd0;
    e   = lq / (1 << T);
    fr  = lq % (1 << T);
    qq  = (((1 << T) + fr) << e) / (1 << T);
    return {1'b0, 16'(qq)};
  endfunction

  // Called at edge+1 with inputs already driven: records accepts, scores consumes, then advances one clock.
  task automatic run_cycle();
    logic [16:0] e;
    #1;
    if (in_valid && in_ready) exp_q.push_back(model(a, b));
    if (out_valid && out_ready) begin
      n_out++;
      check("expected_pending", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("q", 32'(q), 32'(e[15:0]));
        check("dbz", 32'(dbz), 32'(e[16]));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_single(input logic [15:0] av, input logic [7:0] bv,
                             input logic [15:0] lit_q, input logic lit_dbz);
    int n;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    a         = av;
    b         = bv;
    run_cycle();
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 10) begin
      run_cycle();
      n++;
    end
    check("latency", 32'(n), 32'd3);
    check("lit_q", 32'(q), 32'(lit_q));
    check("lit_dbz", 32'(dbz), 32'(lit_dbz));
    run_cycle();
  endtask

  initial begin
    int          sent;
    int          start_out;
    int          r;
    logic [15:0] held_q;
    logic        held_dbz;
    logic        stall;
    logic [16:0] mv;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_valid", 32'(out_valid), 32'd0);
    check("reset_q", 32'(q), 32'd0);
    check("reset_dbz", 32'(dbz), 32'd0);
    rst_n = 1'b1;
    #1;
    check("ready_after_reset", 32'(in_ready), 32'd1);

    // Directed single beats with hand-derived results.
    send_single(16'd100,   8'd10,  16'd10,    1'b0);
    send_single(16'd200,   8'd7,   16'd29,    1'b0);
    send_single(16'd64,    8'd96,  16'd0,     1'b0);
    send_single(16'd255,   8'd1,   16'd252,   1'b0);
    send_single(16'd65535, 8'd1,   16'd64512, 1'b0);
    send_single(16'd1,     8'd255, 16'd0,     1'b0);
    send_single(16'd1234,  8'd0,   16'hFFFF,  1'b1);
    send_single(16'd0,     8'd5,   16'd0,     1'b0);
    send_single(16'd0,     8'd0,   16'hFFFF,  1'b1);

    // Backpressure: eight beats, downstream stalled for cycles 2..6.
    sent      = 0;
    start_out = n_out;
    held_q    = '0;
    for (int c = 0; c < 40 && (sent < 8 || exp_q.size() != 0); c++) begin
      out_ready = !(c >= 2 && c <= 6);
      in_valid  = (sent < 8);
      a         = 16'($urandom);
      b         = 8'($urandom_range(1, 255));
      #1;
      if (c == 4) check("bp_ready_low", 32'(in_ready), 32'd0);
      if (c == 3) held_q = q;
      if (c >= 4 && c <= 6) begin
        check("bp_hold_valid", 32'(out_valid), 32'd1);
        check("bp_hold_q", 32'(q), 32'(held_q));
      end
      if (in_valid && in_ready) sent++;
      run_cycle();
    end
    in_valid = 1'b0;
    check("bp_sent", 32'(sent), 32'd8);
    check("bp_out_count", 32'(n_out - start_out), 32'd8);

    // Random streaming with random backpressure and occasional zero operands.
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      r         = $urandom_range(0, 9);
      a         = (r == 0) ? 16'd0 : (r == 2) ? 16'($urandom_range(0, 255)) : 16'($urandom);
      b         = (r == 1) ? 8'd0 : (r == 3) ? 8'($urandom_range(1, 3)) : 8'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      #1;
      stall    = out_valid && !out_ready;
      held_q   = q;
      held_dbz = dbz;
      run_cycle();
      if (stall) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_q", 32'(q), 32'(held_q));
        check("hold_dbz", 32'(dbz), 32'(held_dbz));
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) run_cycle();
    check("drain_empty", 32'(exp_q.size()), 32'd0);

    // Reset with three beats in flight.
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      a        = 16'($urandom_range(1, 65535));
      b        = 8'($urandom_range(1, 255));
      run_cycle();
    end
    in_valid = 1'b0;
    check("pre_reset_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("reset_async_valid", 32'(out_valid), 32'd0);
    check("reset_async_q", 32'(q), 32'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("ready_after_midreset", 32'(in_ready), 32'd1);
    check("valid_after_midreset", 32'(out_valid), 32'd0);
    mv = model(16'd50000, 8'd3);
    send_single(16'd50000, 8'd3, mv[15:0], mv[16]);
    check("final_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
